// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: opcodes, flag bundle
// layout and the slice-width helper.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic sign;
    logic zero;
  } flags_t;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One registered carry-chain slice: adds its own SW-bit field using the carry
// from the previous slice and forwards operands and partial result untouched.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             vld_in,
  input  logic             op_in,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  output logic             vld,
  output logic             op,
  output logic             carry,
  output logic             carry_msb,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);

  localparam int LO = IDX * SW;

  logic [SW:0]      sum;
  logic [WIDTH-1:0] s_nxt;
  logic             msb_c;

  always_comb begin
    sum   = {1'b0, a_in[LO +: SW]} + {1'b0, b_in[LO +: SW]} + {{SW{1'b0}}, carry_in};
    // Carry into the slice's top bit, recovered from sum ^ a ^ b at that bit.
    msb_c = sum[SW-1] ^ a_in[LO+SW-1] ^ b_in[LO+SW-1];
    s_nxt = s_in;
    s_nxt[LO +: SW] = sum[SW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld       <= 1'b0;
      op        <= OP_ADD;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      a         <= '0;
      b         <= '0;
      s         <= '0;
    end else if (load) begin
      vld       <= vld_in;
      op        <= op_in;
      carry     <= sum[SW];
      carry_msb <= msb_c;
      a         <= a_in;
      b         <= b_in;
      s         <= s_nxt;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit with valid/ready handshakes: the carry chain is
// cut into STAGES registered slices (skewed pipeline), flags formed at the end.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             sign,
  output logic             zero
);

  localparam int SW = slice_width(WIDTH, STAGES);

  function automatic flags_t form_flags(input logic v, input logic is_sub,
                                        input logic c_out, input logic c_msb,
                                        input logic [WIDTH-1:0] r);
    flags_t f;
    f = '0;
    if (v) begin
      f.cout     = is_sub ? ~c_out : c_out;
      f.overflow = c_msb ^ c_out;
      f.sign     = r[WIDTH-1] ^ f.overflow;
      f.zero     = ~|r;
    end
    return f;
  endfunction

  logic             vld_p   [STAGES+1];
  logic             op_p    [STAGES+1];
  logic             carry_p [STAGES+1];
  logic             msb_p   [STAGES];
  logic [WIDTH-1:0] a_p     [STAGES+1];
  logic [WIDTH-1:0] b_p     [STAGES+1];
  logic [WIDTH-1:0] s_p     [STAGES+1];
  logic [STAGES:0]  rdy;
  flags_t           flags;
  logic             unused_bits;

  // Subtraction is a + ~b + ~cin, so inversion happens once at the entry.
  assign vld_p[0]   = in_valid;
  assign op_p[0]    = op;
  assign a_p[0]     = a;
  assign b_p[0]     = (op == OP_SUB) ? ~b : b;
  assign carry_p[0] = (op == OP_SUB) ? ~cin : cin;
  assign s_p[0]     = '0;

  // Stage k may load when it is empty or its content moves on this cycle.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~vld_p[k+1] | rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    addsub_slice #(
      .WIDTH(WIDTH),
      .SW   (SW),
      .IDX  (k)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .load     (rdy[k]),
      .vld_in   (vld_p[k]),
      .op_in    (op_p[k]),
      .carry_in (carry_p[k]),
      .a_in     (a_p[k]),
      .b_in     (b_p[k]),
      .s_in     (s_p[k]),
      .vld      (vld_p[k+1]),
      .op       (op_p[k+1]),
      .carry    (carry_p[k+1]),
      .carry_msb(msb_p[k]),
      .a        (a_p[k+1]),
      .b        (b_p[k+1]),
      .s        (s_p[k+1])
    );
  end

  // Last stage: flags only describe a held result, so they read 0 when empty.
  assign flags = form_flags(vld_p[STAGES], op_p[STAGES] == OP_SUB,
                            carry_p[STAGES], msb_p[STAGES-1], s_p[STAGES]);

  assign out_valid = vld_p[STAGES];
  assign s         = s_p[STAGES];
  assign {cout, overflow, sign, zero} = flags;

  always_comb begin
    unused_bits = ^a_p[STAGES] ^ ^b_p[STAGES];
    for (int k = 0; k < STAGES - 1; k++) begin
      unused_bits = unused_bits ^ msb_p[k];
    end
  end

endmodule
